// File: rtl/quad_updown_driver.sv
// quad_updown_driver: quadrature front end that feeds the up/down command
// inputs of the T-flip-flop up/down counters.
// Path: synchronizer -> per-channel deglitch filter -> registered Gray-step decoder.
// Optional macro QUAD_X1_MODE_EN: x1 decoding (one up strobe on 10->00,
// one down strobe on 00->10); undefined gives x4 decoding (strobe per legal step).
//
// state  | meaning
// S_INIT | sync/filter pipelines settling, decoder idle, ready=0
// S_RUN  | filters and decoder active, ready=1; left only via reset
module quad_updown_driver #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic enc_a,
    input  logic enc_b,
    input  logic clr_err,
    output logic up,
    output logic down,
    output logic dir,
    output logic err,
    output logic ready
);
    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int ICW = $clog2(SYNC_STAGES + FILT_LEN + 1);
    localparam logic [FCW-1:0] FILT_TC = FCW'(FILT_LEN - 1);
    localparam logic [ICW-1:0] INIT_TC = ICW'(SYNC_STAGES + FILT_LEN);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             s_ab;
    logic [1:0]             filt;
    logic [1:0]             prev;
    logic [FCW-1:0]         fcnt [2];
    logic [ICW-1:0]         init_cnt;
    logic [1:0]             pos_cur;
    logic [1:0]             pos_prev;
    logic [1:0]             step;
    logic                   step_fwd;
    logic                   step_bwd;
    logic                   step_bad;
    logic                   fire_up;
    logic                   fire_down;

    // Bit 1 is channel A, bit 0 is channel B, matching the {a,b} phase order.
    assign s_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // Synchronizer chains; the newest sample enters bit 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
        end
    end

    // Map Gray phase onto its position in the 4-step cycle so that a step is
    // a modular difference: +1 forward, -1 backward, 2 means a skipped phase.
    always_comb begin
        pos_cur  = {filt[1], filt[1] ^ filt[0]};
        pos_prev = {prev[1], prev[1] ^ prev[0]};
        step     = pos_cur - pos_prev;
        step_fwd = (step == 2'd1);
        step_bwd = (step == 2'd3);
        step_bad = (step == 2'd2);
`ifdef QUAD_X1_MODE_EN
        fire_up   = step_fwd && (prev == 2'b10);
        fire_down = step_bwd && (prev == 2'b00);
`else
        fire_up   = step_fwd;
        fire_down = step_bwd;
`endif
    end

    // Sequencing FSM with the filters, decoder history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_INIT;
            init_cnt <= '0;
            filt     <= '0;
            prev     <= '0;
            fcnt[0]  <= '0;
            fcnt[1]  <= '0;
            up       <= 1'b0;
            down     <= 1'b0;
            dir      <= 1'b0;
            err      <= 1'b0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    up   <= 1'b0;
                    down <= 1'b0;
                    if (clr_err) begin
                        err <= 1'b0;
                    end
                    // Load both filtered phase and history from the settled
                    // sync outputs so the first RUN cycle sees no step.
                    if (init_cnt == INIT_TC) begin
                        filt  <= s_ab;
                        prev  <= s_ab;
                        state <= S_RUN;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ICW'(1);
                    end
                end
                S_RUN: begin
                    up   <= fire_up;
                    down <= fire_down;
                    if (step_fwd) begin
                        dir <= 1'b1;
                    end else if (step_bwd) begin
                        dir <= 1'b0;
                    end
                    // A detection on the same edge as clr_err keeps the flag.
                    if (step_bad) begin
                        err <= 1'b1;
                    end else if (clr_err) begin
                        err <= 1'b0;
                    end
                    prev <= filt;
                    for (int i = 0; i < 2; i++) begin
                        if (s_ab[i] == filt[i]) begin
                            fcnt[i] <= '0;
                        end else if (fcnt[i] == FILT_TC) begin
                            filt[i] <= s_ab[i];
                            fcnt[i] <= '0;
                        end else begin
                            fcnt[i] <= fcnt[i] + FCW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_updown_driver.sv
// Bench for quad_updown_driver: directed scenarios with literal expectations
// followed by random encoder activity, all checked every cycle against a
// phase-history model. Define QUAD_X1_MODE_EN for both files to test x1 mode.
`timescale 1ns/1ps
module tb_quad_updown_driver;
    localparam int S  = 2;
    localparam int FL = 3;

    localparam logic [1:0] FWD_SEQ [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    localparam logic [1:0] REV_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
`ifdef QUAD_X1_MODE_EN
    localparam int FWD_EXP [4] = '{0, 0, 0, 1};
    localparam int REV_EXP [4] = '{1, 0, 0, 0};
`else
    localparam int FWD_EXP [4] = '{1, 1, 1, 1};
    localparam int REV_EXP [4] = '{1, 1, 1, 1};
`endif

    logic clk     = 1'b0;
    logic rstn    = 1'b0;
    logic enc_a   = 1'b0;
    logic enc_b   = 1'b0;
    logic clr_err = 1'b0;
    logic up, down, dir, err, ready;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int up_cnt    = 0;
    int down_cnt  = 0;
    int last_up   = 0;
    int last_down = 0;

    quad_updown_driver #(.SYNC_STAGES(S), .FILT_LEN(FL)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .clr_err(clr_err),
        .up     (up),
        .down   (down),
        .dir    (dir),
        .err    (err),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] hist [$];   // sync pipeline contents, [0] newest, [S-1] visible
    bit         qa [$];     // recent channel samples seen while running
    bit         qb [$];
    int         m_edges;
    bit         m_run;
    logic [1:0] m_filt, m_prevf;
    logic       m_up, m_down, m_dir, m_err, m_ready;

    function automatic int pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic a, input logic b, input logic c);
        logic [1:0] seen, nf;
        int         st;
        bit         ok_a, ok_b;
        if (!r) begin
            hist.delete();
            for (int i = 0; i < S; i++) hist.push_back(2'b00);
            qa.delete();
            qb.delete();
            m_edges = 0; m_run = 0; m_filt = 2'b00; m_prevf = 2'b00;
            m_up = 0; m_down = 0; m_dir = 0; m_err = 0; m_ready = 0;
        end else begin
            seen = hist[S-1];
            m_edges++;
            if (!m_run) begin
                m_up = 0;
                m_down = 0;
                if (c) m_err = 0;
                if (m_edges == S + FL + 1) begin
                    m_run = 1; m_ready = 1; m_filt = seen; m_prevf = seen;
                end
            end else begin
                st = (pos(m_filt) - pos(m_prevf) + 4) % 4;
                m_up = 0;
                m_down = 0;
                if (st == 1) begin
                    m_dir = 1;
`ifdef QUAD_X1_MODE_EN
                    m_up = (m_prevf == 2'b10);
`else
                    m_up = 1;
`endif
                end
                if (st == 3) begin
                    m_dir = 0;
`ifdef QUAD_X1_MODE_EN
                    m_down = (m_prevf == 2'b00);
`else
                    m_down = 1;
`endif
                end
                if (st == 2) m_err = 1;
                else if (c) m_err = 0;
                m_prevf = m_filt;
                // A channel flips once its last FL observed samples all disagree.
                qa.push_front(seen[1]);
                qb.push_front(seen[0]);
                if (qa.size() > FL) void'(qa.pop_back());
                if (qb.size() > FL) void'(qb.pop_back());
                ok_a = (qa.size() == FL);
                ok_b = (qb.size() == FL);
                foreach (qa[i]) if (qa[i] == m_filt[1]) ok_a = 0;
                foreach (qb[i]) if (qb[i] == m_filt[0]) ok_b = 0;
                nf = m_filt;
                if (ok_a) nf[1] = ~m_filt[1];
                if (ok_b) nf[0] = ~m_filt[0];
                m_filt = nf;
            end
            hist.push_front({a, b});
            void'(hist.pop_back());
        end
    endtask

    // Advance the model at each edge and compare DUT outputs 1 ns later.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(rstn, enc_a, enc_b, clr_err);
            #1;
            tests++;
            if ({up, down, dir, err, ready} !== {m_up, m_down, m_dir, m_err, m_ready}) begin
                fails++;
                $display("FAIL model_cmp cycle %0d: up/down/dir/err/ready got %b%b%b%b%b, expected %b%b%b%b%b",
                         cyc, up, down, dir, err, ready, m_up, m_down, m_dir, m_err, m_ready);
            end
            if (up === 1'b1) begin
                up_cnt++;
                last_up = cyc;
            end
            if (down === 1'b1) begin
                down_cnt++;
                last_down = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int u0, d0, cu, lu, cd, ld, cap;

        // 1: reset then INIT timing with encoder parked at 00
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("init_ready_e%0d", k), ready, (k >= 6) ? 1 : 0);
            check($sformatf("init_quiet_e%0d", k), {up, down, err}, 0);
        end
        repeat (4) @(negedge clk);

        // 2: forward sequence
        u0 = up_cnt; d0 = down_cnt;
        for (int i = 0; i < 4; i++) begin
            cu = up_cnt; lu = last_up;
            {enc_a, enc_b} = FWD_SEQ[i];
            cap = cyc + 1;
            repeat (10) @(negedge clk);
            check($sformatf("fwd_up_count_%0d", i), up_cnt - cu, FWD_EXP[i]);
            check($sformatf("fwd_up_latency_%0d", i), last_up, (FWD_EXP[i] != 0) ? cap + 5 : lu);
        end
        check("fwd_down_none", down_cnt - d0, 0);
        check("fwd_dir", dir, 1);

        // 3: reverse sequence
        u0 = up_cnt;
        for (int i = 0; i < 4; i++) begin
            cd = down_cnt; ld = last_down;
            {enc_a, enc_b} = REV_SEQ[i];
            cap = cyc + 1;
            repeat (10) @(negedge clk);
            check($sformatf("rev_down_count_%0d", i), down_cnt - cd, REV_EXP[i]);
            check($sformatf("rev_down_latency_%0d", i), last_down, (REV_EXP[i] != 0) ? cap + 5 : ld);
        end
        check("rev_up_none", up_cnt - u0, 0);
        check("rev_dir", dir, 0);

        // 4: glitch shorter than the filter, then one just long enough
        u0 = up_cnt; d0 = down_cnt;
        enc_a = 1'b1;
        repeat (2) @(negedge clk);
        enc_a = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_up", up_cnt - u0, 0);
        check("glitch_down", down_cnt - d0, 0);
        check("glitch_err", err, 0);
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (10) @(negedge clk);
        check("pulse3_up", up_cnt - u0, 1);
        check("pulse3_down", down_cnt - d0, 1);

        // 5: phase skip, clear, then skip coinciding with clear
        u0 = up_cnt; d0 = down_cnt;
        enc_a = 1'b1; enc_b = 1'b1;
        repeat (10) @(negedge clk);
        check("skip_err", err, 1);
        check("skip_no_strobe", (up_cnt - u0) + (down_cnt - d0), 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", err, 0);
        enc_a = 1'b0; enc_b = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_detect_err", err, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("set_wins", err, 1);
        repeat (5) @(negedge clk);
        check("err_sticky", err, 1);

        // 6: reset on the edge an up strobe is due
        u0 = up_cnt;
        {enc_a, enc_b} = 2'b01;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        {enc_a, enc_b} = 2'b11;
        @(negedge clk);
        check("rst_up", up, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_dropped", up_cnt - u0, 0);
        rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("reinit_ready_e%0d", k), ready, (k >= 6) ? 1 : 0);
        end
        u0 = up_cnt; d0 = down_cnt;
        repeat (20) @(negedge clk);
        check("parked_up", up_cnt - u0, 0);
        check("parked_down", down_cnt - d0, 0);
        check("parked_err", err, 0);

        // Random encoder activity, occasional clears and resets
        for (int it = 0; it < 400; it++) begin
            {enc_a, enc_b} = 2'($urandom_range(0, 3));
            clr_err = ($urandom_range(0, 9) == 0);
            rstn    = ($urandom_range(0, 99) != 0);
            repeat ($urandom_range(1, 10)) @(negedge clk);
            clr_err = 1'b0;
            rstn    = 1'b1;
        end
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
